// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
// Kept in one place so the step ALU and the sequencing FSM decode identically.
package shifter_pkg;

  typedef logic [1:0] mode_t;
  typedef logic [1:0] state_t;

  // Operation select, as presented on the mode port.
  localparam mode_t MODE_SLL = 2'b00;
  localparam mode_t MODE_SRL = 2'b01;
  localparam mode_t MODE_SRA = 2'b10;
  localparam mode_t MODE_ROL = 2'b11;

  // Sequencer states. 2'b11 is unused and recovers to idle.
  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage

// File: rtl/shift_step.sv
// Single combinational shift of a WIDTH-bit word by 0..STEP bits.
// The sequencer calls this once per cycle with the number of bits still owed,
// clipped to STEP, so each instance only needs a STEP-deep barrel.
module shift_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] din_i,
  input  mode_t            mode_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [2*WIDTH-1:0] rot_wide;

  // Select the shift flavour; rotate takes the top half of a doubled word so
  // bits leaving the MSB end re-enter at the LSB end.
  always_comb begin
    rot_wide = {din_i, din_i} << amt_i;
    dout_o   = din_i;
    case (mode_i)
      MODE_SLL: dout_o = din_i << amt_i;
      MODE_SRL: dout_o = din_i >> amt_i;
      MODE_SRA: dout_o = $signed(din_i) >>> amt_i;
      MODE_ROL: dout_o = rot_wide[2*WIDTH-1 -: WIDTH];
      default:  dout_o = din_i;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts a request when idle or finishing, then shifts
// the captured operand by up to STEP bits per cycle until shamt is consumed.
// done pulses for one cycle in the DONE state; dout holds the last result.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STEP    = 1,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  localparam int unsigned AMT_W = $clog2(STEP) + 1;

  // STEP can equal WIDTH, which needs one more bit than SHAMT_W to compare.
  localparam logic [SHAMT_W:0] StepExt = (SHAMT_W + 1)'(STEP);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic               last_step;
  logic [SHAMT_W-1:0] step_k;
  logic [AMT_W-1:0]   step_amt;
  logic [WIDTH-1:0]   step_out;

  // Bits shifted this cycle: min(STEP, rem). When rem > STEP we know STEP is
  // below WIDTH, so the truncated constant is exact on that path.
  always_comb begin
    last_step = {1'b0, rem_q} <= StepExt;
    step_k    = last_step ? rem_q : SHAMT_W'(STEP);
    step_amt  = AMT_W'(step_k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_shift_step (
    .din_i  (work_q),
    .mode_i (mode_q),
    .amt_i  (step_amt),
    .dout_o (step_out)
  );

  // Next-state logic: accept in IDLE/DONE, shift in SHIFT, result on DONE entry.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d = din;
          mode_d = mode;
          rem_d  = shamt;
          if (shamt == '0) begin
            state_d = ST_DONE;
            dout_d  = din;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Requests arriving here are dropped; nothing from the ports is read.
        work_d = step_out;
        rem_d  = rem_q - step_k;
        if (last_step) begin
          state_d = ST_DONE;
          dout_d  = step_out;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset clears everything so an interrupted op leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SLL;
      work_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
    end
  end

  // Status decodes straight from the state flop, so reset forces them at once.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
    dout = dout_q;
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: two instances (STEP=1, STEP=4) checked
// against an arithmetic reference model with directed and random requests.
module tb_seq_shifter;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a [2];
  logic [1:0]   mode_a  [2];
  logic [4:0]   shamt_a [2];
  logic [W-1:0] din_a   [2];
  logic         busy_a  [2];
  logic         done_a  [2];
  logic [W-1:0] dout_a  [2];

  int tests_run = 0;
  int fails     = 0;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .mode(mode_a[0]), .shamt(shamt_a[0]),
    .din(din_a[0]), .busy(busy_a[0]), .done(done_a[0]), .dout(dout_a[0])
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .mode(mode_a[1]), .shamt(shamt_a[1]),
    .din(din_a[1]), .busy(busy_a[1]), .done(done_a[1]), .dout(dout_a[1])
  );

  function automatic int step_of(input int idx);
    return (idx == 0) ? 1 : 4;
  endfunction

  // Reference: whole-word shift of the operand by shamt.
  function automatic logic [W-1:0] ref_shift(input logic [1:0] m, input int sh,
                                             input logic [W-1:0] d);
    logic [W-1:0] r;
    case (m)
      2'd0: r = d << sh;
      2'd1: r = d >> sh;
      2'd2: r = $signed(d) >>> sh;
      default: r = (sh == 0) ? d : ((d << sh) | (d >> (W - sh)));
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input int idx, input int sh);
    return 1 + (sh + step_of(idx) - 1) / step_of(idx);
  endfunction

  // Issue one request and wait (bounded) for done. With poke set, start is
  // held high and operands scrambled every busy cycle.
  task automatic run_op(input int idx, input logic [1:0] m, input int sh,
                        input logic [W-1:0] d, input bit poke,
                        output logic [W-1:0] q, output int lat, output bit busy_bad);
    @(negedge clk);
    start_a[idx] = 1'b1;
    mode_a[idx]  = m;
    shamt_a[idx] = 5'(sh);
    din_a[idx]   = d;
    @(posedge clk); #1;
    start_a[idx] = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (done_a[idx] !== 1'b1 && lat < 100) begin
      if (busy_a[idx] !== 1'b1) busy_bad = 1'b1;
      mode_a[idx]  = 2'($urandom);
      shamt_a[idx] = 5'($urandom);
      din_a[idx]   = $urandom;
      if (poke) start_a[idx] = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start_a[idx] = 1'b0;
    if (busy_a[idx] !== 1'b0) busy_bad = 1'b1;
    q = dout_a[idx];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0; mode_a[i] = '0; shamt_a[i] = '0; din_a[i] = '0;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({busy_a[i], done_a[i], dout_a[i]} !== '0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: got busy=%b done=%b dout=%h, want all zero",
                 i, busy_a[i], done_a[i], dout_a[i]);
      end
    end
    // Requests during reset must have no effect.
    start_a[0] = 1'b1; start_a[1] = 1'b1; din_a[0] = 32'h1234; din_a[1] = 32'h5678;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({busy_a[i], done_a[i], dout_a[i]} !== '0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got busy=%b done=%b dout=%h, want all zero",
                 i, busy_a[i], done_a[i], dout_a[i]);
      end
    end
    @(negedge clk);
    start_a[0] = 1'b0; start_a[1] = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int           idx;
    logic [1:0]   m;
    logic [W-1:0] d;
    int           sh;
    logic [W-1:0] q;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t v [8] = '{
      '{0, 2'd0, 32'h0000_0001,  2, 32'h0000_0004,  3},
      '{0, 2'd2, 32'h8000_0000, 31, 32'hFFFF_FFFF, 32},
      '{0, 2'd1, 32'h8000_0000, 31, 32'h0000_0001, 32},
      '{1, 2'd3, 32'h8000_0001,  5, 32'h0000_0030,  3},
      '{0, 2'd0, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1},
      '{0, 2'd1, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1},
      '{1, 2'd2, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1},
      '{1, 2'd3, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF,  1}
    };
    logic [W-1:0] q;
    int lat;
    bit bb;
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].idx, v[i].m, v[i].sh, v[i].d, 1'b0, q, lat, bb);
      tests_run++;
      if (q !== v[i].q) begin
        fails++;
        $display("FAIL directed_dout[%0d]: got %h want %h", i, q, v[i].q);
      end
      tests_run++;
      if (lat != v[i].lat) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, v[i].lat);
      end
      tests_run++;
      if (bb) begin
        fails++;
        $display("FAIL directed_busy[%0d]: got busy mismatch want busy only while shifting", i);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q, d;
    int lat, idx, sh;
    logic [1:0] m;
    bit bb, poke;
    for (int i = 0; i < 40; i++) begin
      idx  = $urandom_range(0, 1);
      m    = 2'($urandom);
      sh   = $urandom_range(0, 31);
      d    = $urandom;
      poke = 1'($urandom);
      run_op(idx, m, sh, d, poke, q, lat, bb);
      tests_run++;
      if (q !== ref_shift(m, sh, d)) begin
        fails++;
        $display("FAIL random_dout[%0d]: dut%0d mode=%0d sh=%0d din=%h got %h want %h",
                 i, idx, m, sh, d, q, ref_shift(m, sh, d));
      end
      tests_run++;
      if (lat != exp_lat(idx, sh)) begin
        fails++;
        $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, exp_lat(idx, sh));
      end
      tests_run++;
      if (bb) begin
        fails++;
        $display("FAIL random_busy[%0d]: got busy mismatch want busy only while shifting", i);
      end
      // Sometimes idle a cycle: done must drop and dout must hold.
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        tests_run++;
        if (done_a[idx] !== 1'b0 || dout_a[idx] !== q) begin
          fails++;
          $display("FAIL random_pulse[%0d]: got done=%b dout=%h want done=0 dout=%h",
                   i, done_a[idx], dout_a[idx], q);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic exp_done;
    // shamt=0 with start held: a done and fresh result every cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_a[0] = 1'b1; shamt_a[0] = '0; mode_a[0] = 2'($urandom);
      d = $urandom;
      din_a[0] = d;
      @(posedge clk); #1;
      tests_run++;
      if (done_a[0] !== 1'b1 || dout_a[0] !== d) begin
        fails++;
        $display("FAIL b2b_zero[%0d]: got done=%b dout=%h want done=1 dout=%h",
                 i, done_a[0], dout_a[0], d);
      end
    end
    @(negedge clk);
    start_a[0] = 1'b0;
    // STEP=4, shamt=8 with start held: done every third cycle, no idle gap.
    d = $urandom;
    start_a[1] = 1'b1; shamt_a[1] = 5'd8; mode_a[1] = 2'd1; din_a[1] = d;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      exp_done = (c % 3 == 2);
      tests_run++;
      if (done_a[1] !== exp_done || (exp_done && dout_a[1] !== (d >> 8))) begin
        fails++;
        $display("FAIL b2b_held[%0d]: got done=%b dout=%h want done=%b dout=%h",
                 c, done_a[1], dout_a[1], exp_done, d >> 8);
      end
    end
    @(negedge clk);
    start_a[1] = 1'b0;
  endtask

  task automatic test_ignore_mid_shift();
    logic [W-1:0] q;
    int lat;
    bit bb;
    run_op(0, 2'd0, 8, 32'h0000_0001, 1'b1, q, lat, bb);
    tests_run++;
    if (q !== 32'h0000_0100 || lat != 9) begin
      fails++;
      $display("FAIL ignore_mid_shift: got dout=%h lat=%0d want dout=00000100 lat=9", q, lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done_a[0] !== 1'b0) begin
      fails++;
      $display("FAIL ignore_single_done: got done=%b want 0", done_a[0]);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] q, d;
    int lat;
    bit bb;
    @(negedge clk);
    start_a[0] = 1'b1; mode_a[0] = 2'd0; shamt_a[0] = 5'd20; din_a[0] = 32'h0000_0003;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_a[0], done_a[0], dout_a[0], dout_a[1]} !== '0) begin
      fails++;
      $display("FAIL reset_async: got busy=%b done=%b dout0=%h dout1=%h want all zero",
               busy_a[0], done_a[0], dout_a[0], dout_a[1]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    d = $urandom;
    run_op(0, 2'd2, 13, d, 1'b0, q, lat, bb);
    tests_run++;
    if (q !== ref_shift(2'd2, 13, d) || lat != 14) begin
      fails++;
      $display("FAIL reset_recover: got dout=%h lat=%0d want dout=%h lat=14",
               q, lat, ref_shift(2'd2, 13, d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_mid_shift();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits; legal values are powers of 2 from 8 to 64.
REQ-002 The block SHALL have parameter STEP, default 1, giving the maximum bits shifted per cycle; legal values are powers of 2 from 1 to WIDTH.
REQ-003 The block SHALL have derived localparam SHAMT_W = log2(WIDTH).
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, width 1: request strobe, sampled on a rising edge.
REQ-007 The block SHALL have port mode, input, width 2: operation select; 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 The block SHALL have port shamt, input, width SHAMT_W: shift amount, 0 to WIDTH-1.
REQ-009 The block SHALL have port din, input, width WIDTH: operand.
REQ-010 The block SHALL have port busy, output, width 1: operation in progress; requests are not accepted.
REQ-011 The block SHALL have port done, output, width 1: one-cycle pulse marking dout valid.
REQ-012 The block SHALL have port dout, output, width WIDTH: result, held stable until the next accepted request completes.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-014 start SHALL be accepted on an edge where the state is IDLE or DONE; start in SHIFT SHALL be ignored and no operand, mode or shamt captured.
REQ-015 On accept, the block SHALL capture din into a working register and capture mode and remaining count rem = shamt.
REQ-016 On accept with shamt = 0, the next state SHALL be DONE with result = din.
REQ-017 On accept with shamt > 0, the next state SHALL be SHIFT.
REQ-018 Each SHIFT edge SHALL shift the working register by k = min(STEP, rem) per the captured mode and set rem = rem - k.
REQ-019 On the SHIFT edge where rem <= STEP, the next state SHALL be DONE.
REQ-020 Mode semantics: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA replicates the captured MSB; ROL moves bits from the MSB end into the LSB end.
REQ-021 Arithmetic SHALL be exact modulo WIDTH bits; no bit beyond WIDTH is retained; shamt is never reduced modulo STEP.
REQ-022 Latency from the accepting edge to done high SHALL be 1 + ceil(shamt/STEP) cycles.
REQ-023 done SHALL be high for exactly the one cycle the FSM spends in DONE.
REQ-024 dout SHALL update only on entry to DONE.
REQ-025 busy SHALL be high exactly in SHIFT.
REQ-026 From DONE without start, the next state SHALL be IDLE.
REQ-027 From DONE with start, the request SHALL be accepted (back-to-back), giving one done pulse per request and no idle gap.
REQ-028 mode, shamt and din changes while busy SHALL NOT affect the operation in flight.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy 0, done 0, dout 0, rem 0 and the working register to 0, independent of clk.
REQ-030 An operation interrupted by reset SHALL be discarded: no done pulse and no dout update.
REQ-031 After rst_n deasserts, the first edge SHALL accept start normally.

Structure
REQ-032 Shared package shifter_pkg SHALL hold the mode encodings (MODE_SLL/SRL/SRA/ROL) and the FSM state encodings, for reuse by the ALU and decode.
REQ-033 One combinational sub-module shift_step SHALL be used, computing a single shift of a WIDTH word by 0..STEP bits for a given mode; seq_shifter holds the FSM, counters and registers.

Verification (WIDTH=32 unless noted)
REQ-034 STEP=1, SLL, din=0x00000001, shamt=2 -> done 3 cycles after accept, dout=0x00000004.
REQ-035 STEP=1, SRA, din=0x80000000, shamt=31 -> done 32 cycles after accept, dout=0xFFFFFFFF; repeat with SRL -> 0x00000001.
REQ-036 STEP=4, ROL, din=0x80000001, shamt=5 -> done 3 cycles after accept, dout=0x00000030.
REQ-037 shamt=0, any mode, din=0xDEADBEEF -> done 1 cycle after accept, dout=0xDEADBEEF; start held high -> back-to-back accepts, done each qualifying cycle.
REQ-038 STEP=1, SLL, shamt=8 with a second start and changed din mid-SHIFT -> second request ignored, single done with the first result.
REQ-039 rst_n pulsed low mid-SHIFT -> outputs 0 immediately, no done pulse; a new request afterwards completes with correct latency.
